// File: rtl/booth_controller_6_bit.sv
// Control FSM for a radix-2 Booth multiplier: sequences the A/Q/Q-1/M datapath
// through WIDTH check/shift iterations and emits a one-cycle done pulse.
module booth_controller_6_bit #(
   parameter int WIDTH = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       q0,
   input  logic       qm1,
   output logic       busy,
   output logic       done,
   output logic       clra,
   output logic       clrqm1,
   output logic       ldq,
   output logic       ldm,
   output logic       lda,
   output logic       addsub,
   output logic       shra,
   output logic       shrq,
   output logic       ldqm1,
   output logic [3:0] count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      CHECK = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [3:0] ITERS = 4'(WIDTH);

   state_t state;
   logic   in_check;

   // Add/sub decode must track q0/qm1 in the same cycle, so it stays combinational.
   assign in_check = (state == CHECK);
   assign lda      = in_check & (q0 ^ qm1);
   assign addsub   = in_check & q0 & ~qm1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         clra   <= 1'b0;
         clrqm1 <= 1'b0;
         ldq    <= 1'b0;
         ldm    <= 1'b0;
         shra   <= 1'b0;
         shrq   <= 1'b0;
         ldqm1  <= 1'b0;
      end else begin
         // Outputs are registered from the state being entered; pulses self-clear.
         busy   <= 1'b0;
         done   <= 1'b0;
         clra   <= 1'b0;
         clrqm1 <= 1'b0;
         ldq    <= 1'b0;
         ldm    <= 1'b0;
         shra   <= 1'b0;
         shrq   <= 1'b0;
         ldqm1  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= INIT;
                  busy   <= 1'b1;
                  clra   <= 1'b1;
                  clrqm1 <= 1'b1;
                  ldq    <= 1'b1;
                  ldm    <= 1'b1;
                  count  <= ITERS;
               end
            end
            INIT: begin
               state <= CHECK;
               busy  <= 1'b1;
            end
            CHECK: begin
               state <= SHIFT;
               busy  <= 1'b1;
               shra  <= 1'b1;
               shrq  <= 1'b1;
               ldqm1 <= 1'b1;
            end
            SHIFT: begin
               count <= (count == 4'd0) ? 4'd0 : count - 4'd1;
               if (count <= 4'd1) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= CHECK;
                  busy  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               count <= '0;
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase
      end
   end

endmodule
